// File: rtl/tc_timer_pkg.sv
// Shared types and constants for the tc_timer countdown timer: FSM state codes,
// register word offsets and CTRL bit positions.
package tc_timer_pkg;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_t;

    // Word offsets (PrAddr[3:2]); offset 3 is reserved.
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions; MODE occupies two bits starting at TC_MODE.
    localparam int TC_EN   = 0;
    localparam int TC_MODE = 1;
    localparam int TC_IM   = 3;

    // Only mode 1 reloads; modes 0, 2 and 3 all behave as one-shot.
    localparam logic [1:0] TC_MODE_RELOAD = 2'd1;

    // Field order matches the CTRL bit layout so the struct reads back directly.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    function automatic logic [31:0] ctrl_word(input tc_ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage

// File: rtl/tc_timer_prescaler.sv
// Cycle prescaler for tc_timer: counts 0..PRESCALE-1 while run is high and
// flags the last cycle of each period with tick.
module tc_prescaler
    import tc_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int             W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with interrupt output.
// Define TC_TIMER_PRESCALE_EN to slow COUNT down by PRESCALE cycles per step.
module tc_timer
    import tc_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("tc_timer: PRESCALE must be at least 2");
    end

    tc_state_t   state;
    tc_ctrl_t    ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        tick;

    logic ctrl_wr;
    logic preset_wr;
    logic mode_reload;

    assign ctrl_wr     = sel && we && (addr == TC_CTRL);
    assign preset_wr   = sel && we && (addr == TC_PRESET);
    assign mode_reload = (ctrl.mode == TC_MODE_RELOAD);

`ifdef TC_TIMER_PRESCALE_EN
    logic psc_clr;
    logic psc_run;

    assign psc_clr = (state == TC_LOAD) || (state == TC_IDLE);
    assign psc_run = (state == TC_CNT);

    tc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (psc_clr),
        .run   (psc_run),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TC_IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset <= wdata;
            end

            case (state)
                TC_IDLE: begin
                    if (ctrl.en) begin
                        state <= TC_LOAD;
                    end
                end
                TC_LOAD: begin
                    count <= preset;
                    state <= TC_CNT;
                end
                TC_CNT: begin
                    if (!ctrl.en) begin
                        state <= TC_IDLE;
                    end else if (count == 32'd0) begin
                        state    <= TC_INT;
                        irq_flag <= 1'b1;
                    end else if (tick) begin
                        count <= count - 32'd1;
                    end
                end
                TC_INT: begin
                    if (mode_reload) begin
                        irq_flag <= 1'b0;
                        state    <= TC_LOAD;
                    end else begin
                        ctrl.en <= 1'b0;
                        state   <= TC_IDLE;
                    end
                end
                default: state <= TC_IDLE;
            endcase

            // Placed last so a bus CTRL write overrides the FSM's EN clear and
            // flag update on the same edge.
            if (ctrl_wr) begin
                ctrl.en   <= wdata[TC_EN];
                ctrl.mode <= wdata[TC_MODE +: 2];
                ctrl.im   <= wdata[TC_IM];
                irq_flag  <= 1'b0;
            end
        end
    end

    assign irq = ctrl.im && irq_flag;

    // NOTE: rdata gets a default before the case so every path assigns it and
    // no latch is inferred.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            TC_CTRL:   rdata = ctrl_word(ctrl);
            TC_PRESET: rdata = preset;
            TC_COUNT:  rdata = count;
            default:   rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer; the prescale scenario runs only
// when TC_TIMER_PRESCALE_EN is defined.
module tb_tc_timer;
    import tc_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    tc_timer #(
        .PRESCALE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a; #1;
        d = rdata;
    endtask

    task automatic apply_reset;
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        apply_reset();
        bus_read(TC_CTRL, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl got %h want %h", d, 32'd0); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        bus_write(TC_PRESET, 32'd3);
        bus_write(TC_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL prereset_count got %0d want 3", d); end
        reset = 1'b1; #1;
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midreset_count got %0d want 0", d); end
        bus_read(TC_CTRL, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midreset_ctrl got %h want 0", d); end
        bus_read(TC_PRESET, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midreset_preset got %0d want 0", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq got %b want 0", irq); end
        n_vec++; if (dut.state !== TC_IDLE) begin n_err++; $display("FAIL midreset_state got %0d want %0d", dut.state, TC_IDLE); end
        reset = 1'b0;
        @(posedge clk); #1;
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL postreset_count got %0d want 0", d); end
        n_vec++; if (dut.state !== TC_IDLE) begin n_err++; $display("FAIL postreset_state got %0d want %0d", dut.state, TC_IDLE); end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        int          e;
        apply_reset();
        bus_write(TC_PRESET, 32'd5);
        bus_write(TC_CTRL, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            e = (k < 2) ? 0 : 5 - (k - 2);
            if (e < 0) e = 0;
            bus_read(TC_COUNT, d);
            n_vec++; if (d !== 32'(e)) begin n_err++; $display("FAIL oneshot_count k=%0d got %0d want %0d", k, d, e); end
            n_vec++; if (irq !== (k >= 8)) begin n_err++; $display("FAIL oneshot_irq k=%0d got %b want %b", k, irq, (k >= 8)); end
        end
        bus_read(TC_CTRL, d);
        n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl_en_cleared got %h want 8", d); end
        bus_write(TC_CTRL, 32'h0);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_clear got %b want 0", irq); end
    endtask

    task automatic test_reload;
        logic [31:0] d;
        int          p;
        int          e;
        apply_reset();
        bus_write(TC_PRESET, 32'd2);
        bus_write(TC_CTRL, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            p = (k - 2) % 5;
            e = (k < 2) ? 0 : (p == 0) ? 2 : (p == 1) ? 1 : 0;
            bus_read(TC_COUNT, d);
            n_vec++; if (d !== 32'(e)) begin n_err++; $display("FAIL reload_count k=%0d got %0d want %0d", k, d, e); end
            n_vec++; if (irq !== (k >= 5 && (k - 5) % 5 == 0)) begin
                n_err++; $display("FAIL reload_irq k=%0d got %b want %b", k, irq, (k >= 5 && (k - 5) % 5 == 0));
            end
        end
        bus_write(TC_CTRL, 32'h0);
    endtask

    task automatic test_zero_preset;
        logic [31:0] d;
        apply_reset();
        bus_write(TC_PRESET, 32'd0);
        bus_write(TC_CTRL, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_vec++; if (irq !== (k == 3)) begin n_err++; $display("FAIL zero_irq k=%0d got %b want %b", k, irq, (k == 3)); end
        end
        // CTRL write lands on the same edge the FSM clears EN.
        bus_write(TC_CTRL, 32'h9);
        bus_read(TC_CTRL, d);
        n_vec++; if (d !== 32'h9) begin n_err++; $display("FAIL bus_wins_ctrl got %h want 9", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL bus_wins_irq_clear got %b want 0", irq); end
        for (int k = 5; k <= 7; k++) begin
            @(posedge clk); #1;
            n_vec++; if (irq !== (k == 7)) begin n_err++; $display("FAIL bus_wins_irq k=%0d got %b want %b", k, irq, (k == 7)); end
        end

        apply_reset();
        bus_write(TC_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (dut.irq_flag !== 1'b1) begin n_err++; $display("FAIL masked_flag got %b want 1", dut.irq_flag); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq got %b want 0", irq); end
        bus_write(TC_CTRL, 32'h8);
        n_vec++; if (dut.irq_flag !== 1'b0) begin n_err++; $display("FAIL unmask_flag_cleared got %b want 0", dut.irq_flag); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL unmask_irq got %b want 0", irq); end
    endtask

    task automatic test_disable;
        logic [31:0] d;
        apply_reset();
        bus_write(TC_PRESET, 32'd10);
        bus_write(TC_CTRL, 32'h9);
        repeat (3) @(posedge clk);
        #1;
        bus_write(TC_PRESET, 32'd3);
        @(posedge clk); #1;
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd7) begin n_err++; $display("FAIL preset_during_cnt got %0d want 7", d); end
        bus_write(TC_CTRL, 32'h8);
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL disable_count got %0d want 6", d); end
        repeat (4) @(posedge clk);
        #1;
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL disable_hold got %0d want 6", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL disable_irq got %b want 0", irq); end
        n_vec++; if (dut.state !== TC_IDLE) begin n_err++; $display("FAIL disable_state got %0d want %0d", dut.state, TC_IDLE); end
        bus_write(TC_COUNT, 32'h1234);
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL count_write_ignored got %h want 6", d); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reserved_read got %h want 0", d); end
        bus_read(TC_PRESET, d);
        n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL preset_readback got %0d want 3", d); end
        bus_write(TC_CTRL, 32'h9);
        repeat (2) @(posedge clk);
        #1;
        bus_read(TC_COUNT, d);
        n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL reload_new_preset got %0d want 3", d); end
        bus_write(TC_CTRL, 32'h0);
    endtask

`ifdef TC_TIMER_PRESCALE_EN
    task automatic test_prescale;
        logic [31:0] d;
        int          e;
        apply_reset();
        bus_write(TC_PRESET, 32'd5);
        bus_write(TC_CTRL, 32'h9);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            e = (k < 2) ? 0 : 5 - (k - 2) / 4;
            if (e < 0) e = 0;
            bus_read(TC_COUNT, d);
            n_vec++; if (d !== 32'(e)) begin n_err++; $display("FAIL prescale_count k=%0d got %0d want %0d", k, d, e); end
            n_vec++; if (irq !== (k >= 23)) begin n_err++; $display("FAIL prescale_irq k=%0d got %b want %b", k, irq, (k >= 23)); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef TC_TIMER_PRESCALE_EN
        test_prescale();
`else
        test_oneshot();
        test_reload();
        test_zero_preset();
        test_disable();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
